grf_wb_sink: RTL and testbench
==============================

Name: grf_wb_sink

Overview:
- General register file plus write-trace buffer; the consumer end of the writeback interface.
- Accepts the writeback stage's register-write enable, address, data and PC. Updates the 32x32 register array and serves two combinational read ports to decode, with same-cycle write-through bypass.
- Logs every architectural write into a small FIFO. A testbench or debug consumer drains the FIFO over a valid/ready handshake.

Parameters:
- DEPTH, 4, trace FIFO entries; power of two, at least 2.
- PTR_W, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-low.
- we  input  1  register write enable from writeback.
- wa  input  5  write register number.
- wd  input  32  write data.
- wpc  input  32  PC of the writing instruction, used for trace only.
- ra1  input  5  read address, port 1.
- ra2  input  5  read address, port 2.
- rd1  output  32  read data, port 1.
- rd2  output  32  read data, port 2.
- trace_valid  output  1  FIFO head entry valid.
- trace_ready  input  1  consumer accepts the head entry.
- trace_pc  output  32  head entry PC.
- trace_addr  output  5  head entry register number.
- trace_data  output  32  head entry data.
- trace_count  output  PTR_W+1  current occupancy, 0..DEPTH.
- trace_overflow  output  1  sticky flag: a write was dropped from the trace.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately regardless of clk):
  - All 32 registers = 0.
  - FIFO pointers and count = 0.
  - trace_overflow = 0, trace_valid = 0.
  - trace_pc/trace_addr/trace_data = 0.
- Register write:
  - Occurs at posedge clk when we=1 and wa!=0; reg[wa] <= wd.
  - we=1 with wa=0 has no effect: register 0 is hardwired to 0 and is never logged.
- Read ports (combinational, identical for port 1 and port 2):
  - ra==0 -> rd=0.
  - else if we=1 and wa==ra -> rd=wd (bypass of the pending write).
  - else rd=reg[ra].
  - Zero-cycle latency; both ports may read the same address.
- Trace push:
  - Condition at posedge: push = we && wa!=0.
  - Entry = {wpc, wa, wd}, written at the tail; tail increments modulo DEPTH.
- Trace pop:
  - Condition at posedge: pop = trace_valid && trace_ready; head increments modulo DEPTH.
- Handshake:
  - trace_valid = (count!=0).
  - The head entry is held stable while trace_valid=1 and trace_ready=0.
  - trace_ready while empty is ignored.
- Head output when empty: trace_pc/trace_addr/trace_data = 0.
- Count update:
  - push only -> +1.
  - pop only -> -1.
  - push and pop together -> unchanged, both performed.
- Full (count==DEPTH):
  - push without pop -> the entry is dropped, the register is still written, trace_overflow <= 1.
  - push with pop -> accepted, no overflow.
- trace_overflow clears only on reset.
- Empty plus push in the same cycle: the entry becomes visible at the head the next cycle; no FIFO bypass.
- Pointer wrap: the tail goes DEPTH-1 -> 0; ordering is preserved across the wrap.
- Reset during traffic: all entries are discarded and outputs return to reset values immediately.

Test Plan:
- Reset, then write wa=5 wd=0x12345678 wpc=0x00003000 and read ra1=5 in the following cycle:
  - rd1=0x12345678.
  - trace_valid=1, trace_pc=0x00003000, trace_addr=5, trace_data=0x12345678, trace_count=1.
- we=1, wa=0, wd=0xFFFFFFFF:
  - Next cycle ra1=0 -> rd1=0.
  - trace_count unchanged.
- Bypass: reg 7 holds 0x11111111; in the same cycle drive we=1, wa=7, wd=0x22222222, ra1=7, ra2=7:
  - rd1=rd2=0x22222222 before the edge.
  - After the edge, with we=0, both still read 0x22222222.
- trace_ready=0, six writes to regs 1..6:
  - trace_count=4, trace_overflow=1, head trace_addr=1.
  - Then trace_ready=1 -> addrs 1,2,3,4 pop in order; reg6 still holds its written value.
- FIFO full, then push and pop in the same cycle:
  - count stays 4, overflow stays 0.
  - Popped entry is the oldest; the new entry appears after the remaining three.
  - Run more than 8 such cycles to exercise pointer wrap.
- Assert reset=0 asynchronously mid-cycle with count=3 and registers nonzero:
  - Immediately trace_valid=0, count=0, rd1 for any ra = 0.
  - After release, the first write logs at head.

Source files
------------

// File: rtl/grf_wb_sink.sv
// General register file with write-through read ports, plus a small FIFO that
// records every architectural register write for a debug or trace consumer.
module grf_wb_sink #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [4:0]       wa,
    input  logic [31:0]      wd,
    input  logic [31:0]      wpc,
    input  logic [4:0]       ra1,
    input  logic [4:0]       ra2,
    output logic [31:0]      rd1,
    output logic [31:0]      rd2,
    output logic             trace_valid,
    input  logic             trace_ready,
    output logic [31:0]      trace_pc,
    output logic [4:0]       trace_addr,
    output logic [31:0]      trace_data,
    output logic [PTR_W:0]   trace_count,
    output logic             trace_overflow
);

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [31:0]      regs [32];
    logic [31:0]      mem_pc   [DEPTH];
    logic [4:0]       mem_addr [DEPTH];
    logic [31:0]      mem_data [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic             overflow;
    logic             push;
    logic             pop;
    logic             full;
    logic             push_acc;

    assign push     = we && (wa != 5'd0);
    assign full     = (count == CNT_FULL);
    assign pop      = trace_valid && trace_ready;
    // A full FIFO can still take a new entry when the head leaves in the same cycle.
    assign push_acc = push && (!full || pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs <= '{default: '0};
        end else if (push) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0)            ? 32'd0 :
                 (we && (wa == ra1))      ? wd    : regs[ra1];
    assign rd2 = (ra2 == 5'd0)            ? 32'd0 :
                 (we && (wa == ra2))      ? wd    : regs[ra2];

    // Entry storage needs no reset: nothing is visible unless count is nonzero.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_pc[tail]   <= wpc;
            mem_addr[tail] <= wa;
            mem_data[tail] <= wd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_acc) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push_acc, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign trace_valid    = (count != '0);
    assign trace_count    = count;
    assign trace_overflow = overflow;
    assign trace_pc       = trace_valid ? mem_pc[head]   : 32'd0;
    assign trace_addr     = trace_valid ? mem_addr[head] : 5'd0;
    assign trace_data     = trace_valid ? mem_data[head] : 32'd0;

endmodule

// File: tb/tb_grf_wb_sink.sv
// Directed bench for grf_wb_sink: register file reads/bypass and trace FIFO
// ordering, overflow, simultaneous push/pop with wrap, and asynchronous reset.
module tb_grf_wb_sink;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] wpc;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [4:0]  trace_addr;
    logic [31:0] trace_data;
    logic [2:0]  trace_count;
    logic        trace_overflow;

    int n_cmp = 0;
    int n_err = 0;

    grf_wb_sink #(.DEPTH(4), .PTR_W(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .we             (we),
        .wa             (wa),
        .wd             (wd),
        .wpc            (wpc),
        .ra1            (ra1),
        .ra2            (ra2),
        .rd1            (rd1),
        .rd2            (rd2),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_pc       (trace_pc),
        .trace_addr     (trace_addr),
        .trace_data     (trace_data),
        .trace_count    (trace_count),
        .trace_overflow (trace_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Drives one writeback cycle; returns 1 time unit after the capturing edge.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        we = 1'b1; wa = a; wd = d; wpc = p;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        ra1 = 5'd5; ra2 = 5'd31;
        reset = 1'b1; #1; reset = 1'b0; #1;
        n_cmp++; if (rd1 !== 32'd0) begin n_err++; $display("FAIL reset_rd1: got %h want %h", rd1, 32'd0); end
        n_cmp++; if (rd2 !== 32'd0) begin n_err++; $display("FAIL reset_rd2: got %h want %h", rd2, 32'd0); end
        n_cmp++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", trace_valid); end
        n_cmp++; if (trace_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", trace_count); end
        n_cmp++; if (trace_overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", trace_overflow); end
        n_cmp++; if (trace_pc !== 32'd0) begin n_err++; $display("FAIL reset_pc: got %h want 0", trace_pc); end
        n_cmp++; if (trace_addr !== 5'd0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", trace_addr); end
        n_cmp++; if (trace_data !== 32'd0) begin n_err++; $display("FAIL reset_data: got %h want 0", trace_data); end
        #10; reset = 1'b1;
    endtask

    task automatic test_write_read();
        do_write(5'd5, 32'h12345678, 32'h00003000);
        ra1 = 5'd5; #1;
        n_cmp++; if (rd1 !== 32'h12345678) begin n_err++; $display("FAIL wr_rd1: got %h want %h", rd1, 32'h12345678); end
        n_cmp++; if (trace_valid !== 1'b1) begin n_err++; $display("FAIL wr_valid: got %b want 1", trace_valid); end
        n_cmp++; if (trace_pc !== 32'h00003000) begin n_err++; $display("FAIL wr_pc: got %h want %h", trace_pc, 32'h00003000); end
        n_cmp++; if (trace_addr !== 5'd5) begin n_err++; $display("FAIL wr_addr: got %0d want 5", trace_addr); end
        n_cmp++; if (trace_data !== 32'h12345678) begin n_err++; $display("FAIL wr_data: got %h want %h", trace_data, 32'h12345678); end
        n_cmp++; if (trace_count !== 3'd1) begin n_err++; $display("FAIL wr_count: got %0d want 1", trace_count); end
        trace_ready = 1'b1; step(); trace_ready = 1'b0;
        n_cmp++; if (trace_count !== 3'd0) begin n_err++; $display("FAIL wr_drain_count: got %0d want 0", trace_count); end
        n_cmp++; if (trace_pc !== 32'd0) begin n_err++; $display("FAIL wr_empty_pc: got %h want 0", trace_pc); end
        // Ready while empty must be ignored.
        trace_ready = 1'b1; step(); trace_ready = 1'b0;
        n_cmp++; if (trace_count !== 3'd0) begin n_err++; $display("FAIL empty_ready_count: got %0d want 0", trace_count); end
    endtask

    task automatic test_zero_write();
        ra1 = 5'd0;
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; wpc = 32'h00000040; #1;
        n_cmp++; if (rd1 !== 32'd0) begin n_err++; $display("FAIL zero_bypass_rd1: got %h want 0", rd1); end
        step(); we = 1'b0; #1;
        n_cmp++; if (rd1 !== 32'd0) begin n_err++; $display("FAIL zero_rd1: got %h want 0", rd1); end
        n_cmp++; if (trace_count !== 3'd0) begin n_err++; $display("FAIL zero_count: got %0d want 0", trace_count); end
    endtask

    task automatic test_bypass();
        do_write(5'd7, 32'h11111111, 32'h00000100);
        ra1 = 5'd7; ra2 = 5'd7; #1;
        n_cmp++; if (rd1 !== 32'h11111111) begin n_err++; $display("FAIL byp_old_rd1: got %h want %h", rd1, 32'h11111111); end
        we = 1'b1; wa = 5'd7; wd = 32'h22222222; wpc = 32'h00000104; #1;
        n_cmp++; if (rd1 !== 32'h22222222) begin n_err++; $display("FAIL byp_rd1: got %h want %h", rd1, 32'h22222222); end
        n_cmp++; if (rd2 !== 32'h22222222) begin n_err++; $display("FAIL byp_rd2: got %h want %h", rd2, 32'h22222222); end
        step(); we = 1'b0; #1;
        n_cmp++; if (rd1 !== 32'h22222222) begin n_err++; $display("FAIL byp_after_rd1: got %h want %h", rd1, 32'h22222222); end
        n_cmp++; if (rd2 !== 32'h22222222) begin n_err++; $display("FAIL byp_after_rd2: got %h want %h", rd2, 32'h22222222); end
        n_cmp++; if (trace_count !== 3'd2) begin n_err++; $display("FAIL byp_count: got %0d want 2", trace_count); end
        trace_ready = 1'b1; step(); step(); trace_ready = 1'b0;
        n_cmp++; if (trace_count !== 3'd0) begin n_err++; $display("FAIL byp_drain: got %0d want 0", trace_count); end
    endtask

    task automatic test_overflow();
        trace_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            do_write(5'(i), 32'hA000_0000 + 32'(i), 32'h0000_1000 + 32'(4 * i));
        end
        n_cmp++; if (trace_count !== 3'd4) begin n_err++; $display("FAIL ovf_count: got %0d want 4", trace_count); end
        n_cmp++; if (trace_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", trace_overflow); end
        n_cmp++; if (trace_addr !== 5'd1) begin n_err++; $display("FAIL ovf_head: got %0d want 1", trace_addr); end
        trace_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            n_cmp++; if (trace_addr !== 5'(k)) begin n_err++; $display("FAIL ovf_pop_addr%0d: got %0d want %0d", k, trace_addr, k); end
            n_cmp++; if (trace_pc !== 32'h0000_1000 + 32'(4 * k)) begin n_err++; $display("FAIL ovf_pop_pc%0d: got %h want %h", k, trace_pc, 32'h0000_1000 + 32'(4 * k)); end
            step();
        end
        trace_ready = 1'b0;
        ra1 = 5'd6; ra2 = 5'd5; #1;
        n_cmp++; if (trace_count !== 3'd0) begin n_err++; $display("FAIL ovf_drained: got %0d want 0", trace_count); end
        n_cmp++; if (rd1 !== 32'hA000_0006) begin n_err++; $display("FAIL ovf_reg6: got %h want %h", rd1, 32'hA000_0006); end
        n_cmp++; if (rd2 !== 32'hA000_0005) begin n_err++; $display("FAIL ovf_reg5: got %h want %h", rd2, 32'hA000_0005); end
        n_cmp++; if (trace_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", trace_overflow); end
    endtask

    task automatic test_back_to_back();
        #2; reset = 1'b0; #2; reset = 1'b1;
        n_cmp++; if (trace_overflow !== 1'b0) begin n_err++; $display("FAIL b2b_ovf_clear: got %b want 0", trace_overflow); end
        @(posedge clk); #1;
        for (int n = 1; n <= 4; n++) begin
            do_write(5'(n), 32'h0000_0100 + 32'(n), 32'h0000_2000 + 32'(n));
        end
        n_cmp++; if (trace_count !== 3'd4) begin n_err++; $display("FAIL b2b_fill: got %0d want 4", trace_count); end
        trace_ready = 1'b1;
        for (int n = 5; n <= 14; n++) begin
            we = 1'b1; wa = 5'(n); wd = 32'h0000_0100 + 32'(n); wpc = 32'h0000_2000 + 32'(n); #1;
            n_cmp++; if (trace_data !== 32'h0000_0100 + 32'(n - 4)) begin n_err++; $display("FAIL b2b_head%0d: got %h want %h", n, trace_data, 32'h0000_0100 + 32'(n - 4)); end
            step();
            n_cmp++; if (trace_count !== 3'd4) begin n_err++; $display("FAIL b2b_count%0d: got %0d want 4", n, trace_count); end
            n_cmp++; if (trace_overflow !== 1'b0) begin n_err++; $display("FAIL b2b_ovf%0d: got %b want 0", n, trace_overflow); end
        end
        we = 1'b0;
        for (int n = 11; n <= 14; n++) begin
            n_cmp++; if (trace_addr !== 5'(n)) begin n_err++; $display("FAIL b2b_tail_addr%0d: got %0d want %0d", n, trace_addr, n); end
            n_cmp++; if (trace_data !== 32'h0000_0100 + 32'(n)) begin n_err++; $display("FAIL b2b_tail_data%0d: got %h want %h", n, trace_data, 32'h0000_0100 + 32'(n)); end
            step();
        end
        trace_ready = 1'b0;
        n_cmp++; if (trace_count !== 3'd0) begin n_err++; $display("FAIL b2b_empty: got %0d want 0", trace_count); end
    endtask

    task automatic test_reset_mid();
        trace_ready = 1'b0;
        do_write(5'd8,  32'h8888_0008, 32'h0000_0800);
        do_write(5'd9,  32'h9999_0009, 32'h0000_0804);
        do_write(5'd10, 32'hAAAA_000A, 32'h0000_0808);
        ra1 = 5'd8; ra2 = 5'd9; #1;
        n_cmp++; if (trace_count !== 3'd3) begin n_err++; $display("FAIL mid_pre_count: got %0d want 3", trace_count); end
        n_cmp++; if (rd1 !== 32'h8888_0008) begin n_err++; $display("FAIL mid_pre_rd1: got %h want %h", rd1, 32'h8888_0008); end
        reset = 1'b0; #1;
        n_cmp++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", trace_valid); end
        n_cmp++; if (trace_count !== 3'd0) begin n_err++; $display("FAIL mid_count: got %0d want 0", trace_count); end
        n_cmp++; if (rd1 !== 32'd0) begin n_err++; $display("FAIL mid_rd1: got %h want 0", rd1); end
        n_cmp++; if (rd2 !== 32'd0) begin n_err++; $display("FAIL mid_rd2: got %h want 0", rd2); end
        n_cmp++; if (trace_addr !== 5'd0) begin n_err++; $display("FAIL mid_addr: got %0d want 0", trace_addr); end
        #2; reset = 1'b1;
        @(posedge clk); #1;
        ra1 = 5'd10; #1;
        n_cmp++; if (rd1 !== 32'd0) begin n_err++; $display("FAIL mid_post_reg10: got %h want 0", rd1); end
        do_write(5'd12, 32'hCAFE_F00D, 32'h0000_4444);
        n_cmp++; if (trace_valid !== 1'b1) begin n_err++; $display("FAIL mid_first_valid: got %b want 1", trace_valid); end
        n_cmp++; if (trace_addr !== 5'd12) begin n_err++; $display("FAIL mid_first_addr: got %0d want 12", trace_addr); end
        n_cmp++; if (trace_data !== 32'hCAFE_F00D) begin n_err++; $display("FAIL mid_first_data: got %h want %h", trace_data, 32'hCAFE_F00D); end
        n_cmp++; if (trace_pc !== 32'h0000_4444) begin n_err++; $display("FAIL mid_first_pc: got %h want %h", trace_pc, 32'h0000_4444); end
        n_cmp++; if (trace_count !== 3'd1) begin n_err++; $display("FAIL mid_first_count: got %0d want 1", trace_count); end
    endtask

    initial begin
        we = 1'b0; wa = 5'd0; wd = 32'd0; wpc = 32'd0;
        ra1 = 5'd0; ra2 = 5'd0; trace_ready = 1'b0;
        test_reset();
        test_write_read();
        test_zero_write();
        test_bypass();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
